rom_fetch: RTL and testbench

- Instruction fetch unit for the 8-bit RISC core; acts as the initiator (reader) side of the program ROM interface.
- Drives ROM address, read and enable, then captures the opcode byte and, for two-byte instructions, the operand byte.
- Resolves JMP, ACL and RET internally using a PC and a return-address stack.
- Hands all remaining instructions to decode over a valid/ready handshake.

---
 rtl/rom_fetch.sv | 107 ++++++++++
 tb/tb_rom_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch.sv
// rom_fetch: program-ROM fetch unit; resolves JMP/ACL/RET with a return stack
// and hands every other instruction to decode over valid/ready.
module rom_fetch #(
  parameter int          STACK_DEPTH = 4,
  parameter logic [7:0]  RESET_PC    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rom_addr,
  output logic       rom_read,
  output logic       rom_ena,
  input  logic [7:0] rom_data,
  output logic [7:0] ir_op,
  output logic [7:0] ir_arg,
  output logic       ir_two,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] pc,
  output logic       halted,
  output logic       stack_err
);
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int SW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic [2:0] {FETCH_OP, FETCH_ARG, BRANCH, ISSUE, HALT} state_t;
  state_t        r_st;
  logic [7:0]    r_pc, r_op, r_arg;
  logic          r_two, r_err;
  logic [PW-1:0] r_sp;
  logic [7:0]    r_stk [STACK_DEPTH];
  logic          w_fetch, w_two, w_full, w_empty, w_push;
  logic [3:0]    w_cls;
  logic [PW-1:0] w_top;
  assign w_fetch     = r_st == FETCH_OP || r_st == FETCH_ARG;
  assign w_two       = rom_data[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'hC};
  assign w_cls       = r_op[7:4];
  assign w_full      = r_sp == PW'(STACK_DEPTH);
  assign w_empty     = r_sp == '0;
  assign w_top       = r_sp - PW'(1);
  assign w_push      = r_st == BRANCH && w_cls == 4'hC && !w_full;
  assign rom_addr    = r_pc;
  assign rom_read    = w_fetch;
  assign rom_ena     = w_fetch;
  assign ir_op       = r_op;
  assign ir_arg      = r_arg;
  assign ir_two      = r_two;
  assign pc          = r_pc;
  assign instr_valid = r_st == ISSUE;
  assign halted      = r_st == HALT;
  assign stack_err   = r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st  <= FETCH_OP;
      r_pc  <= RESET_PC;
      r_sp  <= '0;
      r_op  <= '0;
      r_arg <= '0;
      r_two <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_st)
        FETCH_OP: begin
          r_op <= rom_data;
          r_pc <= r_pc + 8'd1;
          if (w_two) r_st <= FETCH_ARG;
          else if (rom_data[7:4] == 4'hD) r_st <= BRANCH;
          else begin
            r_arg <= '0;
            r_two <= 1'b0;
            r_st  <= ISSUE;
          end
        end
        FETCH_ARG: begin
          r_arg <= rom_data;
          r_two <= 1'b1;
          r_pc  <= r_pc + 8'd1;
          r_st  <= (w_cls == 4'h5 || w_cls == 4'hC) ? BRANCH : ISSUE;
        end
        BRANCH: begin
          if (w_cls == 4'h5) begin
            r_pc <= r_arg;
            r_st <= FETCH_OP;
          end else if (w_cls == 4'hC) begin
            if (w_full) begin
              r_err <= 1'b1;
              r_st  <= HALT;
            end else begin
              r_sp <= r_sp + PW'(1);
              r_pc <= r_arg;
              r_st <= FETCH_OP;
            end
          end else if (w_empty) begin
            r_err <= 1'b1;
            r_st  <= HALT;
          end else begin
            r_sp <= w_top;
            r_pc <= r_stk[w_top[SW-1:0]];
            r_st <= FETCH_OP;
          end
        end
        ISSUE: if (instr_ready) r_st <= (w_cls == 4'hF) ? HALT : FETCH_OP;
        default: r_st <= HALT;
      endcase
    end
  end
  // Return-address storage needs no reset; validity is tracked by r_sp.
  always_ff @(posedge clk) if (w_push) r_stk[r_sp[SW-1:0]] <= r_pc;
endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed tables plus random ROM images checked against an
// instruction-level model of the fetch unit.
module tb_rom_fetch;
  localparam int DEPTH = 2;
  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic       two;
    logic [7:0] pc;
    int         cyc;
  } iss_t;
  logic       clk = 1'b0, rst = 1'b0, instr_ready = 1'b1;
  logic [7:0] rom_addr, rom_data, ir_op, ir_arg, pc;
  logic       rom_read, rom_ena, ir_two, instr_valid, halted, stack_err;
  logic [7:0] rom [256];
  iss_t       issq[$], mq[$];
  bit         m_hlt, m_err, m_pcok;
  logic [7:0] m_pc;
  int         n_chk = 0, n_fail = 0, rdy_mode = 0;
  iss_t       tbl [5];
  rom_fetch #(.STACK_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_read(rom_read),
    .rom_ena(rom_ena), .rom_data(rom_data), .ir_op(ir_op), .ir_arg(ir_arg),
    .ir_two(ir_two), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .halted(halted), .stack_err(stack_err)
  );
  assign rom_data = (rom_read && rom_ena) ? rom[rom_addr] : 8'hzz;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask
  task automatic run(input int budget);
    issq.delete();
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      instr_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (instr_valid || halted) chk("rom_idle", {rom_read, rom_ena}, 0);
      if (instr_valid && instr_ready) issq.push_back('{ir_op, ir_arg, ir_two, pc, c});
      if (halted) break;
    end
  endtask
  // Instruction-level reference: walks the ROM image as a program.
  task automatic model();
    logic [7:0] p, op, arg;
    logic [3:0] c;
    logic [7:0] stk[$];
    bit two;
    mq.delete();
    p = 8'h00; m_hlt = 0; m_err = 0; m_pcok = 1;
    for (int s = 0; s < 4000 && !m_hlt && mq.size() < 400; s++) begin
      op = rom[p]; p = p + 8'd1; c = op[7:4]; arg = 8'h00;
      two = c inside {4'h1, 4'h2, 4'h3, 4'h5, 4'hC};
      if (two) begin arg = rom[p]; p = p + 8'd1; end
      if (c == 4'h5) p = arg;
      else if (c == 4'hC) begin
        if (stk.size() == DEPTH) begin m_err = 1; m_hlt = 1; m_pcok = 0; end
        else begin stk.push_back(p); p = arg; end
      end else if (c == 4'hD) begin
        if (stk.size() == 0) begin m_err = 1; m_hlt = 1; end
        else p = stk.pop_back();
      end else begin
        mq.push_back('{op, arg, two, p, 0});
        if (c == 4'hF) m_hlt = 1;
      end
    end
    m_pc = p;
  endtask
  task automatic compare();
    int k;
    k = issq.size();
    model();
    if (halted) begin
      chk("halt_agree", m_hlt, 1);
      chk("stack_err", stack_err, m_err);
      chk("n_issued", k, mq.size());
      if (m_pcok) chk("final_pc", pc, m_pc);
    end else begin
      chk("err_running", stack_err, 0);
      chk("model_long_enough", mq.size() >= k, 1);
    end
    for (int i = 0; i < k && i < mq.size(); i++) begin
      chk("iss_op", issq[i].op, mq[i].op);
      chk("iss_arg", issq[i].arg, mq[i].arg);
      chk("iss_two", issq[i].two, mq[i].two);
      chk("iss_pc", issq[i].pc, mq[i].pc);
    end
  endtask
  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'd1, 1};
    tbl[1] = '{8'h11, 8'h41, 1'b1, 8'd3, 4};
    tbl[2] = '{8'h60, 8'h00, 1'b0, 8'd4, 6};
    tbl[3] = '{8'hB0, 8'h00, 1'b0, 8'd51, 0};
    tbl[4] = '{8'hF0, 8'h00, 1'b0, 8'd49, 0};
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h11; rom[2] = 8'h41; rom[3] = 8'h60;
    rom[4] = 8'h50; rom[5] = 8'h0E; rom[14] = 8'h50; rom[15] = 8'h17;
    rom[16] = 8'hF0; rom[23] = 8'h50; rom[24] = 8'h2E;
    rom[46] = 8'hC0; rom[47] = 8'h32; rom[48] = 8'hF0; rom[50] = 8'hB0; rom[51] = 8'hD0;
    rst = 1'b0;
    #2;
    chk("rst_pc", pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_ir", {ir_op, ir_arg, ir_two}, 0);
    chk("rst_rom_strobe", {rom_read, rom_ena}, 2'b11);
    do_reset();
    rdy_mode = 0;
    run(100);
    chk("dir_count", issq.size(), 5);
    for (int i = 0; i < 5 && i < issq.size(); i++) begin
      chk("dir_op", issq[i].op, tbl[i].op);
      chk("dir_arg", issq[i].arg, tbl[i].arg);
      chk("dir_two", issq[i].two, tbl[i].two);
      chk("dir_pc", issq[i].pc, tbl[i].pc);
      if (tbl[i].cyc != 0) chk("dir_cycle", issq[i].cyc, tbl[i].cyc);
    end
    chk("dir_halted", halted, 1);
    chk("dir_err", stack_err, 0);
    compare();
    clear_rom();
    rom[0] = 8'hD0;
    do_reset();
    run(50);
    chk("ret_empty_count", issq.size(), 0);
    chk("ret_empty_err", stack_err, 1);
    chk("ret_empty_halted", halted, 1);
    chk("ret_empty_pc", pc, 1);
    rst = 1'b0;
    #1;
    chk("rst_from_halt", {halted, stack_err}, 0);
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'h10; rom[16] = 8'hC0; rom[17] = 8'h20;
    rom[32] = 8'hC0; rom[33] = 8'h30; rom[48] = 8'hF0;
    do_reset();
    run(50);
    chk("ovf_count", issq.size(), 0);
    chk("ovf_err", stack_err, 1);
    chk("ovf_halted", halted, 1);
    clear_rom();
    rom[0] = 8'h50; rom[1] = 8'hFF; rom[255] = 8'h11;
    do_reset();
    run(50);
    chk("wrap_count", issq.size(), 2);
    if (issq.size() > 0) begin
      chk("wrap_arg", issq[0].arg, 8'h50);
      chk("wrap_pc", issq[0].pc, 8'h01);
    end
    compare();
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h41;
    do_reset();
    instr_ready = 1'b0;
    for (int c = 0; c < 10 && !instr_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_reach", instr_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", instr_valid, 1);
      chk("stall_op", ir_op, 8'h11);
      chk("stall_arg", ir_arg, 8'h41);
      chk("stall_pc", pc, 8'h02);
    end
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", instr_valid, 0);
    chk("abort_pc", pc, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    rdy_mode = 1;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      do_reset();
      run(600);
      compare();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
